// File: rtl/digit_rx_m10.sv
`default_nettype none
// ============================================================================
// Module   : digit_rx_m10
// Purpose  : Receiver/checker for the tens-of-minutes digit (xx:mx). Decodes
//            the sampled digit to registered 7-segment drive, tracks the
//            digit/carry sequence of the 0..MAX_VAL counter, declares lock
//            after LOCK_N consecutive correct transitions, emits an hour tick
//            on validated MAX_VAL -> 0 rollover and keeps sticky and counted
//            error status for sequence faults seen while locked.
// Options  : SEG_ACTIVE_LOW_EN - when defined, seg_o drives a common-anode
//            display (every segment bit inverted, reset 7'h40, dash 7'h3F).
// Revision : 1.0 - initial release
// ============================================================================
module digit_rx_m10 #(
  parameter int MAX_VAL  = 5,
  parameter int HALF_VAL = 2,
  parameter int LOCK_N   = 3,
  parameter int ECW      = 8
) (
  input  logic           clk10m_i,
  input  logic           rstn_i,
  input  logic [3:0]     digit_i,
  input  logic           carry_i,
  input  logic           clr_err_i,
  output logic [6:0]     seg_o,
  output logic           hour_tick_o,
  output logic           sync_o,
  output logic           err_o,
  output logic [ECW-1:0] err_cnt_o
);

  // Parameters narrowed to the widths of the signals they are compared with.
  localparam logic [3:0]     MAX_D   = 4'(MAX_VAL);
  localparam logic [3:0]     HALF_D  = 4'(HALF_VAL);
  localparam logic [2:0]     LOCK_C  = 3'(LOCK_N);
  localparam logic [ECW-1:0] CNT_ONE = ECW'(1);

  // Segment polarity: XOR mask applied to the active-high table.
`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [6:0] SEG_MASK = 7'h7F;
`else
  localparam logic [6:0] SEG_MASK = 7'h00;
`endif
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_RST  = 7'h3F ^ SEG_MASK;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] prev_q;
  logic       carry_q;
  logic [2:0] good_cnt;

  logic       oor;
  logic [3:0] exp_d;
  logic       exp_c;
  logic       good;
  logic [6:0] seg_hi;
  logic [6:0] seg_nxt;
  logic       cnt_full;

  // Classify the current sample against the successor of the last valid one.
  always_comb begin
    oor      = (digit_i > MAX_D);
    exp_d    = (prev_q == MAX_D) ? 4'd0 : (prev_q + 4'd1);
    // The carry toggles when the counter leaves HALF_VAL (falls) or
    // MAX_VAL (rises, the hour boundary).
    exp_c    = carry_q ^ ((prev_q == HALF_D) || (prev_q == MAX_D));
    good     = !oor && (digit_i == exp_d) && (carry_i == exp_c);
    cnt_full = &err_cnt_o;
  end

  // Active-high 7-segment decode {g,f,e,d,c,b,a}; out-of-range shows a dash.
  always_comb begin
    seg_hi = SEG_DASH;
    if (!oor) begin
      case (digit_i)
        4'd0:    seg_hi = 7'h3F;
        4'd1:    seg_hi = 7'h06;
        4'd2:    seg_hi = 7'h5B;
        4'd3:    seg_hi = 7'h4F;
        4'd4:    seg_hi = 7'h66;
        4'd5:    seg_hi = 7'h6D;
        4'd6:    seg_hi = 7'h7D;
        4'd7:    seg_hi = 7'h07;
        4'd8:    seg_hi = 7'h7F;
        4'd9:    seg_hi = 7'h6F;
        default: seg_hi = SEG_DASH;
      endcase
    end
    seg_nxt = seg_hi ^ SEG_MASK;
  end

  // Sequence tracker FSM with all status outputs registered.
  always_ff @(posedge clk10m_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= SEARCH;
      prev_q      <= 4'd0;
      carry_q     <= 1'b1;
      good_cnt    <= 3'd0;
      seg_o       <= SEG_RST;
      hour_tick_o <= 1'b0;
      sync_o      <= 1'b0;
      err_o       <= 1'b0;
      err_cnt_o   <= '0;
    end else begin
      seg_o       <= seg_nxt;
      hour_tick_o <= 1'b0;

      // Out-of-range samples never become the reference for the next one.
      if (!oor) begin
        prev_q  <= digit_i;
        carry_q <= carry_i;
      end

      // Clear first; an error on the same edge below overrides it.
      if (clr_err_i) begin
        err_o     <= 1'b0;
        err_cnt_o <= '0;
      end

      case (state)
        SEARCH: begin
          if (!oor) begin
            state    <= TRACK;
            good_cnt <= 3'd0;
          end
        end

        TRACK: begin
          if (good) begin
            if ((good_cnt + 3'd1) == LOCK_C) begin
              state    <= LOCKED;
              sync_o   <= 1'b1;
              good_cnt <= 3'd0;
            end else begin
              good_cnt <= good_cnt + 3'd1;
            end
          end else begin
            good_cnt <= 3'd0;
          end
        end

        LOCKED: begin
          if (good) begin
            if (prev_q == MAX_D) begin
              hour_tick_o <= 1'b1;
            end
          end else begin
            err_o <= 1'b1;
            if (clr_err_i) begin
              err_cnt_o <= CNT_ONE;
            end else if (!cnt_full) begin
              err_cnt_o <= err_cnt_o + CNT_ONE;
            end
            state    <= TRACK;
            sync_o   <= 1'b0;
            good_cnt <= 3'd0;
          end
        end

        default: begin
          state    <= SEARCH;
          sync_o   <= 1'b0;
          good_cnt <= 3'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
